// File: rtl/vic_pkg.sv
// Shared types and constants for the vectored interrupt controller.
// Holds FSM states, config addresses and default sizes.
package vic_pkg;

  localparam int N_SRC_DEF  = 8;
  localparam int ADDR_W_DEF = 5;

  localparam logic [4:0] CFG_MASK     = 5'd0;
  localparam logic [4:0] CFG_MODE     = 5'd1;
  localparam logic [4:0] CFG_VEC_BASE = 5'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVICE = 2'd1,
    GAP     = 2'd2
  } vic_state_t;

endpackage

// File: rtl/vic_irq_sync.sv
// Two-flop synchroniser for one interrupt line.
// Also flags a rising edge of the synchronised value.
module vic_irq_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_line,
  output logic o_sync,
  output logic o_rise
);

  logic s1;
  logic s2;
  logic s3;

  // metastability chain plus one extra stage for edge detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= i_line;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign o_sync = s2;
  assign o_rise = s2 & ~s3;

endmodule

// File: rtl/vic_irq_arbiter.sv
// Interrupt front end: sync, pending, fixed-priority grant.
// Sequences each grant through completion on i_reti.
module vic_irq_arbiter
  import vic_pkg::*;
#(
  parameter int N_SRC  = N_SRC_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SRC-1:0]  i_irq_lines,
  input  logic              i_cfg_we,
  input  logic [4:0]        i_cfg_addr,
  input  logic [15:0]       i_cfg_wdata,
  input  logic              i_reti,
  output logic              o_IRQ,
  output logic [ADDR_W-1:0] o_ISR_addr,
  output logic [3:0]        o_active_id,
  output logic              o_busy,
  output logic [N_SRC-1:0]  o_pending
);

  logic [N_SRC-1:0]  sync;
  logic [N_SRC-1:0]  rise;
  logic [N_SRC-1:0]  pending;
  logic [N_SRC-1:0]  pend_n;
  logic [N_SRC-1:0]  mask;
  logic [N_SRC-1:0]  mode;
  logic [ADDR_W-1:0] vec [N_SRC];
  logic [N_SRC-1:0]  elig;
  logic [N_SRC-1:0]  win_oh;
  logic [3:0]        win_id;
  logic [ADDR_W-1:0] win_vec;
  logic [N_SRC-1:0]  clr;
  logic              reti_q;
  logic              reti_rise;

  vic_state_t        state;
  vic_state_t        state_n;
  logic              irq_q;
  logic              irq_n;
  logic              busy_q;
  logic              busy_n;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_n;
  logic [3:0]        id_q;
  logic [3:0]        id_n;

  logic unused_wdata;
  assign unused_wdata = ^i_cfg_wdata;

  for (genvar g = 0; g < N_SRC; g++) begin : g_sync
    vic_irq_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .i_line (i_irq_lines[g]),
      .o_sync (sync[g]),
      .o_rise (rise[g])
    );
  end

  // config registers; vector table resets to identity
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask <= '0;
      mode <= '0;
      for (int i = 0; i < N_SRC; i++)
        vec[i] <= ADDR_W'(i);
    end else if (i_cfg_we) begin
      if (i_cfg_addr == CFG_MASK)
        mask <= i_cfg_wdata[N_SRC-1:0];
      if (i_cfg_addr == CFG_MODE)
        mode <= i_cfg_wdata[N_SRC-1:0];
      for (int i = 0; i < N_SRC; i++)
        if (i_cfg_addr == 5'(int'(CFG_VEC_BASE) + i))
          vec[i] <= i_cfg_wdata[ADDR_W-1:0];
    end
  end

  // edge sources latch (set beats clear), level sources follow
  always_comb begin
    pend_n = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (mode[i])
        pend_n[i] = rise[i] | (pending[i] & ~clr[i]);
      else
        pend_n[i] = sync[i];
    end
  end

  // pending register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pending <= '0;
    else
      pending <= pend_n;
  end

  // lowest eligible index wins
  always_comb begin
    elig    = pending & mask;
    win_oh  = '0;
    win_id  = '0;
    win_vec = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_oh  = '0;
        win_oh[i] = 1'b1;
        win_id  = 4'(i);
        win_vec = vec[i];
      end
    end
  end

  assign reti_rise = i_reti & ~reti_q;

  // state, request outputs and reti edge history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      irq_q  <= 1'b0;
      busy_q <= 1'b0;
      addr_q <= '0;
      id_q   <= '0;
      reti_q <= 1'b0;
    end else begin
      state  <= state_n;
      irq_q  <= irq_n;
      busy_q <= busy_n;
      addr_q <= addr_n;
      id_q   <= id_n;
      reti_q <= i_reti;
    end
  end

  // grant in IDLE, complete in SERVICE, one dead cycle in GAP
  always_comb begin
    state_n = state;
    irq_n   = irq_q;
    busy_n  = busy_q;
    addr_n  = addr_q;
    id_n    = id_q;
    clr     = '0;
    unique case (state)
      IDLE: begin
        if (|elig) begin
          state_n = SERVICE;
          irq_n   = 1'b1;
          busy_n  = 1'b1;
          addr_n  = win_vec;
          id_n    = win_id;
          clr     = win_oh & mode;
        end
      end
      SERVICE: begin
        if (reti_rise) begin
          state_n = GAP;
          irq_n   = 1'b0;
          busy_n  = 1'b0;
        end
      end
      GAP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign o_IRQ       = irq_q;
  assign o_ISR_addr  = addr_q;
  assign o_active_id = id_q;
  assign o_busy      = busy_q;
  assign o_pending   = pending;

endmodule

// File: tb/tb_vic_irq_arbiter.sv
// Directed self-checking bench for vic_irq_arbiter.
// Each task drives one scenario and checks inline.
module tb_vic_irq_arbiter;

  localparam int N = 8;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic [N-1:0]  lines;
  logic          we;
  logic [4:0]    addr;
  logic [15:0]   wdata;
  logic          reti;
  logic          irq;
  logic [AW-1:0] isr;
  logic [3:0]    id;
  logic          busy;
  logic [N-1:0]  pend;

  int n_chk;
  int n_pass;

  vic_irq_arbiter #(.N_SRC(N), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_irq_lines (lines),
    .i_cfg_we    (we),
    .i_cfg_addr  (addr),
    .i_cfg_wdata (wdata),
    .i_reti      (reti),
    .o_IRQ       (irq),
    .o_ISR_addr  (isr),
    .o_active_id (id),
    .o_busy      (busy),
    .o_pending   (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [4:0] a, input logic [15:0] d);
    we = 1'b1;
    addr = a;
    wdata = d;
    tick();
    we = 1'b0;
    addr = '0;
    wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    lines = '0;
    we = 1'b0;
    addr = '0;
    wdata = '0;
    reti = 1'b0;
    tick();
    tick();
    n_chk++;
    if ({irq, busy, isr, id, pend} !== '0)
      $display("FAIL reset_outputs got irq=%b busy=%b isr=%h id=%h pend=%h want all 0",
               irq, busy, isr, id, pend);
    else n_pass++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_edge_basic();
    cfg(5'd0, 16'h0001);
    cfg(5'd1, 16'h0001);
    cfg(5'd2, 16'h0003);
    lines = 8'h01;
    tick();
    lines = 8'h00;
    tick();
    n_chk++;
    if (pend !== 8'h00)
      $display("FAIL edge_pend_early got %h want 00", pend);
    else n_pass++;
    tick();
    n_chk++;
    if (pend !== 8'h01 || irq !== 1'b0)
      $display("FAIL edge_pend_set got pend=%h irq=%b want 01/0", pend, irq);
    else n_pass++;
    tick();
    n_chk++;
    if (irq !== 1'b1 || isr !== 5'h03 || id !== 4'd0 || busy !== 1'b1 || pend !== 8'h00)
      $display("FAIL edge_grant got irq=%b isr=%h id=%0d busy=%b pend=%h want 1/03/0/1/00",
               irq, isr, id, busy, pend);
    else n_pass++;
    reti = 1'b1;
    tick();
    reti = 1'b0;
    n_chk++;
    if (irq !== 1'b0 || busy !== 1'b0)
      $display("FAIL edge_complete got irq=%b busy=%b want 0/0", irq, busy);
    else n_pass++;
    tick();
    tick();
  endtask

  task automatic test_priority();
    cfg(5'd0, 16'h0024);
    cfg(5'd1, 16'h0024);
    cfg(5'd4, 16'h000A);
    cfg(5'd7, 16'h000B);
    lines = 8'h24;
    tick();
    lines = 8'h00;
    tick();
    tick();
    tick();
    n_chk++;
    if (irq !== 1'b1 || id !== 4'd2 || isr !== 5'h0A || pend !== 8'h20)
      $display("FAIL prio_first got irq=%b id=%0d isr=%h pend=%h want 1/2/0a/20",
               irq, id, isr, pend);
    else n_pass++;
    reti = 1'b1;
    tick();
    reti = 1'b0;
    n_chk++;
    if (irq !== 1'b0)
      $display("FAIL prio_fall got irq=%b want 0", irq);
    else n_pass++;
    tick();
    n_chk++;
    if (irq !== 1'b0)
      $display("FAIL prio_gap got irq=%b want 0", irq);
    else n_pass++;
    tick();
    n_chk++;
    if (irq !== 1'b1 || id !== 4'd5 || isr !== 5'h0B || pend !== 8'h00)
      $display("FAIL prio_second got irq=%b id=%0d isr=%h pend=%h want 1/5/0b/00",
               irq, id, isr, pend);
    else n_pass++;
    reti = 1'b1;
    tick();
    reti = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_level_regrant();
    cfg(5'd0, 16'h0002);
    cfg(5'd1, 16'h0000);
    lines = 8'h02;
    repeat (4) tick();
    n_chk++;
    if (irq !== 1'b1 || id !== 4'd1 || isr !== 5'h01 || pend !== 8'h02)
      $display("FAIL level_grant got irq=%b id=%0d isr=%h pend=%h want 1/1/01/02",
               irq, id, isr, pend);
    else n_pass++;
    reti = 1'b1;
    tick();
    reti = 1'b0;
    n_chk++;
    if (irq !== 1'b0)
      $display("FAIL level_fall got irq=%b want 0", irq);
    else n_pass++;
    tick();
    n_chk++;
    if (irq !== 1'b0)
      $display("FAIL level_gap got irq=%b want 0", irq);
    else n_pass++;
    tick();
    n_chk++;
    if (irq !== 1'b1 || isr !== 5'h01 || id !== 4'd1)
      $display("FAIL level_regrant got irq=%b isr=%h id=%0d want 1/01/1", irq, isr, id);
    else n_pass++;
    lines = 8'h00;
    repeat (3) tick();
    reti = 1'b1;
    tick();
    reti = 1'b0;
    repeat (3) tick();
    n_chk++;
    if (irq !== 1'b0 || busy !== 1'b0 || pend !== 8'h00)
      $display("FAIL level_release got irq=%b busy=%b pend=%h want 0/0/00", irq, busy, pend);
    else n_pass++;
  endtask

  task automatic test_masked_edge();
    cfg(5'd0, 16'h0000);
    cfg(5'd1, 16'h0008);
    lines = 8'h08;
    tick();
    lines = 8'h00;
    repeat (4) tick();
    n_chk++;
    if (irq !== 1'b0 || pend !== 8'h08)
      $display("FAIL masked_hold got irq=%b pend=%h want 0/08", irq, pend);
    else n_pass++;
    cfg(5'd0, 16'h0008);
    n_chk++;
    if (irq !== 1'b0)
      $display("FAIL mask_write_same_edge got irq=%b want 0", irq);
    else n_pass++;
    tick();
    n_chk++;
    if (irq !== 1'b1 || id !== 4'd3 || isr !== 5'h03 || pend !== 8'h00)
      $display("FAIL unmask_grant got irq=%b id=%0d isr=%h pend=%h want 1/3/03/00",
               irq, id, isr, pend);
    else n_pass++;
    reti = 1'b1;
    tick();
    reti = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_service_hold();
    cfg(5'd0, 16'h0001);
    cfg(5'd1, 16'h0001);
    cfg(5'd2, 16'h0007);
    lines = 8'h01;
    tick();
    lines = 8'h00;
    repeat (3) tick();
    n_chk++;
    if (irq !== 1'b1 || isr !== 5'h07)
      $display("FAIL hold_grant got irq=%b isr=%h want 1/07", irq, isr);
    else n_pass++;
    lines = 8'h01;
    tick();
    lines = 8'h00;
    cfg(5'd0, 16'h0000);
    cfg(5'd2, 16'h001F);
    tick();
    n_chk++;
    if (irq !== 1'b1 || isr !== 5'h07 || busy !== 1'b1 || id !== 4'd0)
      $display("FAIL hold_stable got irq=%b isr=%h busy=%b id=%0d want 1/07/1/0",
               irq, isr, busy, id);
    else n_pass++;
    reti = 1'b1;
    tick();
    n_chk++;
    if (irq !== 1'b0 || busy !== 1'b0)
      $display("FAIL hold_complete got irq=%b busy=%b want 0/0", irq, busy);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if (irq !== 1'b0 || busy !== 1'b0)
        $display("FAIL hold_no_regrant got irq=%b busy=%b at %0d want 0/0", irq, busy, i);
      else n_pass++;
    end
    n_chk++;
    if (pend !== 8'h01)
      $display("FAIL hold_pend_kept got %h want 01", pend);
    else n_pass++;
    reti = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    cfg(5'd0, 16'h0001);
    tick();
    n_chk++;
    if (irq !== 1'b1 || isr !== 5'h1F || id !== 4'd0)
      $display("FAIL rearm_grant got irq=%b isr=%h id=%0d want 1/1f/0", irq, isr, id);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++;
    if ({irq, busy, isr, id, pend} !== '0)
      $display("FAIL async_reset got irq=%b busy=%b isr=%h id=%h pend=%h want all 0",
               irq, busy, isr, id, pend);
    else n_pass++;
    tick();
    #2;
    rst = 1'b1;
    repeat (5) tick();
    n_chk++;
    if (irq !== 1'b0 || busy !== 1'b0 || pend !== 8'h00)
      $display("FAIL post_reset_idle got irq=%b busy=%b pend=%h want 0/0/00", irq, busy, pend);
    else n_pass++;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    test_reset();
    test_edge_basic();
    test_priority();
    test_level_regrant();
    test_masked_edge();
    test_service_hold();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vic_irq_arbiter.md
Name: vic_irq_arbiter

Overview:
Front end of the vectored interrupt controller. It collects N_SRC external interrupt lines and synchronises them. Each line is either edge-latched or level-sensitive, under per-source mask and mode configuration. A fixed-priority arbiter then presents one request at a time to vic_ctrl as o_IRQ plus a 5-bit ISR vector, and sequences each request from grant through completion on i_reti.

Parameters:
N_SRC, 8, number of interrupt source lines (1..16).
ADDR_W, 5, width of the ISR vector index driven to vic_ctrl.

Ports:
clk  in  1  system clock, all state on rising edge.
rst  in  1  reset, asynchronous, active-low.
i_irq_lines  in  N_SRC  raw asynchronous interrupt lines; bit 0 has highest priority.
i_cfg_we  in  1  config write strobe, one write per cycle.
i_cfg_addr  in  5  config address: 0=mask, 1=mode, 2..2+N_SRC-1=vector of source (addr-2).
i_cfg_wdata  in  16  write data; low N_SRC bits for mask/mode, low ADDR_W bits for vectors.
i_reti  in  1  return-from-interrupt, level from pipeline; the block uses its rising edge only.
o_IRQ  out  1  interrupt request to vic_ctrl.
o_ISR_addr  out  ADDR_W  vector of the granted source, stable while o_IRQ=1.
o_active_id  out  4  index of the source in service.
o_busy  out  1  1 while a request is granted and not yet completed.
o_pending  out  N_SRC  pending register, for status.

Behaviour:
- Reset (rst=0, asynchronous):
  - o_IRQ=0, o_ISR_addr=0, o_active_id=0, o_busy=0, o_pending=0.
  - mask=0 (all disabled), mode=0 (all level).
  - Vector table entry i resets to i.
  - Synchronisers cleared; FSM returns to IDLE.
  - Reset asserted mid-service drops o_IRQ at once, with no completion.
- Input path, per source:
  - Two-flop synchroniser, then edge detect against the previous synchronised value.
  - Edge mode (mode[i]=1): a rising edge sets pending[i]. Pending is cleared only when that source is granted. If a set and the grant-clear land in the same cycle, set wins.
  - Level mode: pending[i] tracks the synchronised line, with no memory.
  - Latency: a line rising between edges k-1 and k sets pending at edge k+2.
- Arbitration:
  - eligible = pending & mask.
  - Winner is the lowest index set in eligible.
  - Masked edge-mode pending bits are retained and become eligible as soon as they are unmasked.
- FSM states: IDLE, SERVICE, GAP.
  - IDLE: if eligible≠0 at edge e, then at edge e the FSM latches the winner into o_active_id, loads o_ISR_addr from vector[winner], and sets o_IRQ=1 and o_busy=1. It clears pending[winner] if that source is edge-mode, then moves to SERVICE. A line rising before edge k therefore gives o_IRQ=1 after edge k+3.
  - SERVICE: o_IRQ, o_ISR_addr and o_active_id are held. On a rising edge of i_reti, o_IRQ=0 and o_busy=0, then move to GAP. Masking, mode changes or vector writes for the in-service source do not abort it or change o_ISR_addr. A level source dropping during SERVICE does not abort service.
  - GAP: holds o_IRQ low for exactly one cycle so that vic_ctrl sees a fresh rising edge, then moves to IDLE. Back-to-back interrupts therefore have a 2-cycle minimum between o_IRQ pulses (fall, gap, rise).
  - i_reti in IDLE or GAP is ignored.
  - A level source still asserted after completion is re-granted.
- Config:
  - Writes take effect at the next edge.
  - Writes to addresses ≥ 2+N_SRC are ignored.
  - A write to mask in the same cycle the IDLE grant evaluates does not affect that evaluation; the pre-write mask is used.
  - Vector writes use the low ADDR_W bits.
- No nesting: a higher-priority request arriving during SERVICE waits for completion.

Decomposition:
- Package vic_pkg holds:
  - FSM state enum (IDLE, SERVICE, GAP).
  - Config address constants CFG_MASK=0, CFG_MODE=1, CFG_VEC_BASE=2.
  - Default N_SRC and ADDR_W.
- One sub-module, vic_irq_sync: 2-flop synchroniser plus rising-edge detect, one per source, instantiated via generate.
- The priority encoder, pending logic and FSM stay in the top.

Test Plan:
- Reset, then write mask=0x01, mode=0x01, vec0=0x03. Pulse line0 for 1 cycle → pending[0]=1 two edges later; o_IRQ=1 with o_ISR_addr=0x03 one edge after; pending[0] clears at grant.
- Make lines 2 and 5 eligible in the same cycle with mask=0x24 and vectors 0x0A/0x0B → grant id 2 (0x0A). Raise i_reti → o_IRQ low, one GAP cycle, then o_IRQ=1 with id 5 (0x0B).
- Hold level-mode line 1 high with mask=0x02. Complete with i_reti → o_IRQ low for exactly 2 edges, then re-granted with the same vector.
- Edge-mode line 3 pulses while masked → no o_IRQ and pending[3]=1. Write mask=0x08 → o_IRQ=1 within 2 edges.
- During SERVICE of source 0: pulse line 0 again, mask source 0, and hold i_reti high over several cycles → o_ISR_addr unchanged. A single completion occurs; after GAP, source 0 is not re-granted while masked, and pending[0] stays 1.
- Assert rst=0 between clock edges while o_IRQ=1 → o_IRQ, o_busy and o_pending are 0 immediately; after release there is no request until a new stimulus arrives.
